// File: rtl/alu_arbiter_pkg.sv
// Shared RV32 ALU opcode encodings used by the arbiter, its ALU and requesters.
// Contents: package rv with the RV32_ALU_OPCODE enumeration (codes 8..15 unassigned).
package rv;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SLL  = 4'd1,
        ALU_SLT  = 4'd2,
        ALU_SLTU = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_SRX  = 4'd5,
        ALU_OR   = 4'd6,
        ALU_AND  = 4'd7
    } RV32_ALU_OPCODE;

endpackage

// File: rtl/alu_arbiter_alu.sv
// Combinational RV32 ALU shared by both arbiter requesters.
// Ports: i_op1, i_op2 operands; i_opcode operation; o_result 32-bit result.
module alu
    import rv::*;
(
    input  logic [31:0]    i_op1,
    input  logic [31:0]    i_op2,
    input  RV32_ALU_OPCODE i_opcode,
    output logic [31:0]    o_result
);

    logic [4:0] w_shamt;

    assign w_shamt = i_op2[4:0];

    always_comb begin
        o_result = 32'd0;
        case (i_opcode)
            ALU_ADD:  o_result = i_op1 + i_op2;
            ALU_SLL:  o_result = i_op1 << w_shamt;
            ALU_SLT:  o_result = {31'd0, $signed(i_op1) < $signed(i_op2)};
            ALU_SLTU: o_result = {31'd0, i_op1 < i_op2};
            ALU_XOR:  o_result = i_op1 ^ i_op2;
            ALU_SRX:  o_result = i_op1 >> w_shamt;
            ALU_OR:   o_result = i_op1 | i_op2;
            ALU_AND:  o_result = i_op1 & i_op2;
            // Unassigned codes still complete; their value is don't-care.
            default:  o_result = 32'd0;
        endcase
    end

endmodule

// File: rtl/alu_arbiter.sv
// Two-requester round-robin arbiter in front of one shared ALU, with a
// registered, back-pressured result slot per requester.
// Ports: clk, rst_n (sync, active-low); reqN_valid/ready/op1/op2/opcode in;
// rspN_valid/result out, rspN_ready in (N = 0, 1).
module alu_arbiter
    import rv::*;
#(
    parameter int FIRST_PRIO = 0
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           req0_valid,
    output logic           req0_ready,
    input  logic [31:0]    req0_op1,
    input  logic [31:0]    req0_op2,
    input  RV32_ALU_OPCODE req0_opcode,
    output logic           rsp0_valid,
    input  logic           rsp0_ready,
    output logic [31:0]    rsp0_result,
    input  logic           req1_valid,
    output logic           req1_ready,
    input  logic [31:0]    req1_op1,
    input  logic [31:0]    req1_op2,
    input  RV32_ALU_OPCODE req1_opcode,
    output logic           rsp1_valid,
    input  logic           rsp1_ready,
    output logic [31:0]    rsp1_result
);

    // Pointer resets to the other requester so FIRST_PRIO wins first.
    localparam logic P_RST_LAST = (FIRST_PRIO == 0) ? 1'b1 : 1'b0;

    logic           r_last;
    logic           r_rsp0_valid;
    logic           r_rsp1_valid;
    logic [31:0]    r_rsp0_result;
    logic [31:0]    r_rsp1_result;

    logic           w_elig0;
    logic           w_elig1;
    logic           w_gnt0;
    logic           w_gnt1;
    logic [31:0]    w_op1;
    logic [31:0]    w_op2;
    RV32_ALU_OPCODE w_opcode;
    logic [31:0]    w_result;

    // A requester may go only if its result slot is free or draining now.
    assign w_elig0 = req0_valid && (!r_rsp0_valid || rsp0_ready);
    assign w_elig1 = req1_valid && (!r_rsp1_valid || rsp1_ready);

    assign w_gnt0 = rst_n && w_elig0 && (!w_elig1 || r_last);
    assign w_gnt1 = rst_n && w_elig1 && (!w_elig0 || !r_last);

    assign req0_ready = w_gnt0;
    assign req1_ready = w_gnt1;

    assign w_op1    = w_gnt1 ? req1_op1    : req0_op1;
    assign w_op2    = w_gnt1 ? req1_op2    : req0_op2;
    assign w_opcode = w_gnt1 ? req1_opcode : req0_opcode;

    alu u_alu (
        .i_op1    (w_op1),
        .i_op2    (w_op2),
        .i_opcode (w_opcode),
        .o_result (w_result)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_last        <= P_RST_LAST;
            r_rsp0_valid  <= 1'b0;
            r_rsp1_valid  <= 1'b0;
            r_rsp0_result <= 32'd0;
            r_rsp1_result <= 32'd0;
        end else begin
            if (w_gnt0 || w_gnt1) begin
                r_last <= w_gnt1;
            end

            if (w_gnt0) begin
                r_rsp0_valid  <= 1'b1;
                r_rsp0_result <= w_result;
            end else if (rsp0_ready) begin
                r_rsp0_valid  <= 1'b0;
            end

            if (w_gnt1) begin
                r_rsp1_valid  <= 1'b1;
                r_rsp1_result <= w_result;
            end else if (rsp1_ready) begin
                r_rsp1_valid  <= 1'b0;
            end
        end
    end

    assign rsp0_valid  = r_rsp0_valid;
    assign rsp1_valid  = r_rsp1_valid;
    assign rsp0_result = r_rsp0_result;
    assign rsp1_result = r_rsp1_result;

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed cases plus random traffic
// compared every cycle against a behavioural model.
module tb_alu_arbiter;
    import rv::*;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           vld [2];
    logic [31:0]    a   [2];
    logic [31:0]    b   [2];
    RV32_ALU_OPCODE opc [2];
    logic           rr  [2];
    logic           rdy0, rdy1, rv0, rv1;
    logic [31:0]    res0, res1;

    int total = 0;
    int bad   = 0;

    // behavioural model state
    int          m_last;
    bit          m_v  [2];
    logic [31:0] m_r  [2];
    bit          m_ud [2];
    bit          g    [2];
    logic        o_rdy0, o_rdy1;

    always #5 clk = ~clk;

    alu_arbiter #(.FIRST_PRIO(0)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req0_valid  (vld[0]),
        .req0_ready  (rdy0),
        .req0_op1    (a[0]),
        .req0_op2    (b[0]),
        .req0_opcode (opc[0]),
        .rsp0_valid  (rv0),
        .rsp0_ready  (rr[0]),
        .rsp0_result (res0),
        .req1_valid  (vld[1]),
        .req1_ready  (rdy1),
        .req1_op1    (a[1]),
        .req1_op2    (b[1]),
        .req1_opcode (opc[1]),
        .rsp1_valid  (rv1),
        .rsp1_ready  (rr[1]),
        .rsp1_result (res1)
    );

    function automatic logic [31:0] alu_ref(logic [31:0] x, logic [31:0] y,
                                            int code);
        int sh;
        sh = int'(y % 32);
        case (code)
            0: return x + y;
            1: return x << sh;
            2: return ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
            3: return (x < y) ? 32'd1 : 32'd0;
            4: return x ^ y;
            5: return x >> sh;
            6: return x | y;
            7: return x & y;
            default: return 32'd0;
        endcase
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Compare outputs with the model, then advance one clock and the model.
    task automatic step();
        bit e [2];
        #2;
        for (int n = 0; n < 2; n++)
            e[n] = vld[n] && (!m_v[n] || rr[n]);
        g[0] = 0;
        g[1] = 0;
        if (rst_n) begin
            if (e[0] && e[1]) g[(m_last == 0) ? 1 : 0] = 1;
            else if (e[0]) g[0] = 1;
            else if (e[1]) g[1] = 1;
        end
        o_rdy0 = rdy0;
        o_rdy1 = rdy1;
        chk("req0_ready", {31'd0, rdy0}, {31'd0, g[0]});
        chk("req1_ready", {31'd0, rdy1}, {31'd0, g[1]});
        chk("rsp0_valid", {31'd0, rv0}, {31'd0, m_v[0]});
        chk("rsp1_valid", {31'd0, rv1}, {31'd0, m_v[1]});
        if (m_v[0] && !m_ud[0]) chk("rsp0_result", res0, m_r[0]);
        if (m_v[1] && !m_ud[1]) chk("rsp1_result", res1, m_r[1]);
        @(posedge clk);
        if (!rst_n) begin
            m_last = 1;
            for (int n = 0; n < 2; n++) begin
                m_v[n] = 0;
                m_r[n] = 0;
                m_ud[n] = 0;
            end
        end else begin
            for (int n = 0; n < 2; n++) begin
                if (g[n]) begin
                    m_v[n]  = 1;
                    m_r[n]  = alu_ref(a[n], b[n], int'(opc[n]));
                    m_ud[n] = int'(opc[n]) > 7;
                    m_last  = n;
                end else if (rr[n]) begin
                    m_v[n] = 0;
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic drive(int n, bit v, logic [31:0] x, logic [31:0] y,
                         RV32_ALU_OPCODE c);
        vld[n] = v;
        a[n]   = x;
        b[n]   = y;
        opc[n] = c;
    endtask

    task automatic do_reset();
        rst_n = 0;
        vld[0] = 0;
        vld[1] = 0;
        step();
        step();
        rst_n = 1;
    endtask

    initial begin
        rst_n = 0;
        m_last = 1;
        for (int n = 0; n < 2; n++) begin
            drive(n, 0, 0, 0, ALU_ADD);
            rr[n] = 1;
            m_v[n] = 0;
            m_r[n] = 0;
            m_ud[n] = 0;
        end
        @(negedge clk);
        do_reset();
        chk("rst_rsp0_result", res0, 32'd0);
        chk("rst_rsp1_result", res1, 32'd0);
        chk("rst_rsp0_valid", {31'd0, rv0}, 32'd0);

        // single requester ADD
        drive(0, 1, 5, 7, ALU_ADD);
        step();
        vld[0] = 0;
        chk("add_ready0", {31'd0, o_rdy0}, 32'd1);
        chk("add_valid0", {31'd0, rv0}, 32'd1);
        chk("add_result", res0, 32'd12);
        chk("add_valid1", {31'd0, rv1}, 32'd0);

        // contended round robin
        do_reset();
        drive(0, 1, 32'hFFFF_FFFF, 1, ALU_SLT);
        drive(1, 1, 1, 32'hFFFF_FFFF, ALU_SLTU);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("rr_order", {31'd0, o_rdy1}, (i % 2));
            if (i == 0) chk("slt_result", res0, 32'd1);
            if (i == 1) chk("sltu_result", res1, 32'd1);
        end
        vld[1] = 0;

        // wrap and shift boundaries
        drive(0, 1, 32'hFFFF_FFFF, 1, ALU_ADD);
        step();
        chk("add_wrap", res0, 32'd0);
        drive(0, 1, 1, 33, ALU_SLL);
        step();
        chk("sll_33", res0, 32'd2);
        drive(0, 1, 32'h8000_0000, 31, ALU_SRX);
        step();
        chk("srl_31", res0, 32'd1);

        // back-pressure on requester 0
        rr[0] = 0;
        drive(0, 1, 3, 4, ALU_ADD);
        drive(1, 1, 32'hF0, 32'h0F, ALU_XOR);
        step();
        vld[1] = 0;
        chk("bp_ready0", {31'd0, o_rdy0}, 32'd0);
        chk("bp_ready1", {31'd0, o_rdy1}, 32'd1);
        chk("bp_hold", res0, 32'd1);
        step();
        chk("bp_hold2", res0, 32'd1);
        rr[0] = 1;
        step();
        chk("drain_valid", {31'd0, rv0}, 32'd1);
        chk("drain_result", res0, 32'd7);
        drive(0, 1, 10, 20, ALU_ADD);
        step();
        chk("nobubble_valid", {31'd0, rv0}, 32'd1);
        chk("nobubble_result", res0, 32'd30);
        vld[0] = 0;

        // reset right after a grant
        drive(0, 1, 9, 9, ALU_OR);
        step();
        vld[0] = 0;
        rst_n = 0;
        step();
        rst_n = 1;
        chk("rst_flush0", {31'd0, rv0}, 32'd0);
        drive(0, 1, 1, 2, ALU_AND);
        drive(1, 1, 1, 2, ALU_OR);
        step();
        chk("rst_first_prio", {31'd0, o_rdy0}, 32'd1);

        // random traffic with holds honoured
        for (int c = 0; c < 3000; c++) begin
            for (int n = 0; n < 2; n++) begin
                if (!vld[n] || g[n]) begin
                    vld[n] = $urandom_range(0, 2) != 0;
                    a[n] = $urandom;
                    b[n] = ($urandom_range(0, 1) != 0) ? $urandom
                                                       : 32'($urandom_range(0, 40));
                    opc[n] = RV32_ALU_OPCODE'(4'($urandom_range(0, 9)));
                end
                rr[n] = $urandom_range(0, 3) != 0;
            end
            rst_n = $urandom_range(0, 199) != 0;
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1);
    end

endmodule
